// File: rtl/segment_transition_ctl.sv
// segment_transition_ctl
//   Chooses which playback segment is active and decides when to move to a
//   newly requested one. A request is latched on UPDATE_SETTINGS and stays
//   pending until its transition condition is met. The conditions are:
//   index wrap, a system-time target, a GPIO rising edge, or immediate.
//   The block also counts completed loops of the active segment. When the
//   finite repetition count is used up, it either stops playback or, in
//   EXT mode, advances to the next segment.
//
// Ports
//   CLK, RST            clock, asynchronous active-high reset
//   UPDATE_SETTINGS     one-cycle pulse latching REQ_RD_SEGMENT/TRANSITION_*
//   REQ_RD_SEGMENT      requested segment
//   TRANSITION_MODE     0x00 SYNC_IDX, 0x01 SYS_TIME, 0x02 GPIO, 0xF0 EXT,
//                       anything else IMMEDIATE
//   TRANSITION_VALUE    SYS_TIME target, or GPIO line select in [1:0]
//   REP                 per-segment loop counts, segment n at [n*REP_WIDTH +:]
//   WRAP                pulse when the segment index wraps to 0
//   SYS_TIME            free-running system time
//   GPIO_IN             synchronised GPIO inputs
//   SEGMENT             active segment
//   STOP                finite repetitions exhausted
//   PENDING             request armed, condition not yet met
//   SWITCHED            one-cycle pulse when SEGMENT is (re)loaded
//   LOOP_CNT            completed loops of the active segment
module segment_transition_ctl #(
  parameter int NUM_SEGMENT = 4,
  parameter int IDX_WIDTH   = 16,
  parameter int REP_WIDTH   = 16,
  localparam int SEG_WIDTH  = $clog2(NUM_SEGMENT)
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             UPDATE_SETTINGS,
  input  logic [SEG_WIDTH-1:0]             REQ_RD_SEGMENT,
  input  logic [7:0]                       TRANSITION_MODE,
  input  logic [63:0]                      TRANSITION_VALUE,
  input  logic [NUM_SEGMENT*REP_WIDTH-1:0] REP,
  input  logic                             WRAP,
  input  logic [63:0]                      SYS_TIME,
  input  logic [3:0]                       GPIO_IN,
  output logic [SEG_WIDTH-1:0]             SEGMENT,
  output logic                             STOP,
  output logic                             PENDING,
  output logic                             SWITCHED,
  output logic [REP_WIDTH-1:0]             LOOP_CNT
);

  localparam logic [7:0] MODE_SYNC_IDX = 8'h00;
  localparam logic [7:0] MODE_SYS_TIME = 8'h01;
  localparam logic [7:0] MODE_GPIO     = 8'h02;
  localparam logic [7:0] MODE_EXT      = 8'hF0;
  localparam logic [SEG_WIDTH-1:0] LAST_SEG = SEG_WIDTH'(NUM_SEGMENT - 1);

  // Parameter sanity: the block is only meaningful for 2..16 segments.
  // IDX_WIDTH describes the index generator that this block follows.
  // The block itself only sees that generator's WRAP pulse.
  if (IDX_WIDTH < 1 || NUM_SEGMENT < 2 || NUM_SEGMENT > 16) begin : g_bad_params
  end

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALT} state_t;

  state_t               state_q, state_d;
  logic [SEG_WIDTH-1:0] segment_q, segment_d;
  logic [REP_WIDTH-1:0] loop_cnt_q, loop_cnt_d;
  logic                 stop_q, stop_d;
  logic                 pending_q, pending_d;
  logic                 switched_q, switched_d;
  logic                 ext_armed_q, ext_armed_d;
  logic [SEG_WIDTH-1:0] req_q, req_d;
  logic [7:0]           mode_q, mode_d;
  logic [63:0]          value_q, value_d;
  logic [3:0]           gpio_prev_q, gpio_prev_d;

  // Unpack the flat repetition bus into one entry per segment.
  logic [REP_WIDTH-1:0] rep_arr [NUM_SEGMENT];
  for (genvar gi = 0; gi < NUM_SEGMENT; gi++) begin : g_rep
    assign rep_arr[gi] = REP[gi*REP_WIDTH +: REP_WIDTH];
  end

  logic [REP_WIDTH-1:0] rep_cur;
  logic                 rep_hit;
  logic                 req_valid;
  logic [SEG_WIDTH-1:0] seg_succ;
  logic [3:0]           gpio_rise;
  logic                 cond_met;
  logic                 do_switch;
  logic [SEG_WIDTH-1:0] switch_target;

  assign rep_cur   = rep_arr[segment_q];
  // An all-ones count means infinite, so it never hits.
  assign rep_hit   = !(&rep_cur) && (loop_cnt_q == rep_cur);
  assign req_valid = {1'b0, REQ_RD_SEGMENT} < (SEG_WIDTH + 1)'(NUM_SEGMENT);
  assign seg_succ  = (segment_q == LAST_SEG) ? '0 : segment_q + 1'b1;
  assign gpio_rise = GPIO_IN & ~gpio_prev_q;

  always_comb begin
    cond_met = 1'b1;
    case (mode_q)
      MODE_SYNC_IDX: cond_met = WRAP;
      MODE_SYS_TIME: cond_met = (SYS_TIME >= value_q);
      MODE_GPIO:     cond_met = gpio_rise[value_q[1:0]];
      MODE_EXT:      cond_met = WRAP;
      default:       cond_met = 1'b1;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    segment_d     = segment_q;
    loop_cnt_d    = loop_cnt_q;
    stop_d        = stop_q;
    pending_d     = pending_q;
    switched_d    = 1'b0;
    ext_armed_d   = ext_armed_q;
    req_d         = req_q;
    mode_d        = mode_q;
    value_d       = value_q;
    gpio_prev_d   = GPIO_IN;
    do_switch     = 1'b0;
    switch_target = req_q;

    if (UPDATE_SETTINGS && req_valid) begin
      // A new request takes over the whole cycle. Any same-cycle switch
      // or loop event belongs to the settings being replaced, so it is
      // dropped.
      req_d       = REQ_RD_SEGMENT;
      mode_d      = TRANSITION_MODE;
      value_d     = TRANSITION_VALUE;
      ext_armed_d = (TRANSITION_MODE == MODE_EXT);
      state_d     = ST_WAIT;
      pending_d   = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (WRAP) begin
            if (rep_hit) begin
              if (ext_armed_q) begin
                do_switch     = 1'b1;
                switch_target = seg_succ;
              end else begin
                stop_d  = 1'b1;
                state_d = ST_HALT;
              end
            end else if (!(&loop_cnt_q)) begin
              loop_cnt_d = loop_cnt_q + 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (cond_met) begin
            do_switch     = 1'b1;
            switch_target = req_q;
          end else if (WRAP) begin
            // Loop accounting continues while the request waits.
            // Exhaustion only raises STOP, and the request stays pending.
            if (rep_hit) begin
              stop_d = 1'b1;
            end else if (!(&loop_cnt_q)) begin
              loop_cnt_d = loop_cnt_q + 1'b1;
            end
          end
        end
        ST_HALT: ;
        default: state_d = ST_RUN;
      endcase
    end

    if (do_switch) begin
      segment_d  = switch_target;
      loop_cnt_d = '0;
      stop_d     = 1'b0;
      switched_d = 1'b1;
      pending_d  = 1'b0;
      state_d    = ST_RUN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_RUN;
      segment_q   <= '0;
      loop_cnt_q  <= '0;
      stop_q      <= 1'b0;
      pending_q   <= 1'b0;
      switched_q  <= 1'b0;
      ext_armed_q <= 1'b0;
      req_q       <= '0;
      mode_q      <= '0;
      value_q     <= '0;
      gpio_prev_q <= '0;
    end else begin
      state_q     <= state_d;
      segment_q   <= segment_d;
      loop_cnt_q  <= loop_cnt_d;
      stop_q      <= stop_d;
      pending_q   <= pending_d;
      switched_q  <= switched_d;
      ext_armed_q <= ext_armed_d;
      req_q       <= req_d;
      mode_q      <= mode_d;
      value_q     <= value_d;
      gpio_prev_q <= gpio_prev_d;
    end
  end

  assign SEGMENT  = segment_q;
  assign STOP     = stop_q;
  assign PENDING  = pending_q;
  assign SWITCHED = switched_q;
  assign LOOP_CNT = loop_cnt_q;

endmodule

// File: tb/tb_segment_transition_ctl.sv
module tb_segment_transition_ctl;

  logic        clk;
  logic        rst;
  logic        upd;
  logic [1:0]  req;
  logic [7:0]  mode;
  logic [63:0] val;
  logic [63:0] rep_flat;
  logic        wrap;
  logic [63:0] systime;
  logic [3:0]  gpio;
  logic [1:0]  seg;
  logic        stop;
  logic        pend;
  logic        sw;
  logic [15:0] cnt;

  segment_transition_ctl dut (
    .CLK              (clk),
    .RST              (rst),
    .UPDATE_SETTINGS  (upd),
    .REQ_RD_SEGMENT   (req),
    .TRANSITION_MODE  (mode),
    .TRANSITION_VALUE (val),
    .REP              (rep_flat),
    .WRAP             (wrap),
    .SYS_TIME         (systime),
    .GPIO_IN          (gpio),
    .SEGMENT          (seg),
    .STOP             (stop),
    .PENDING          (pend),
    .SWITCHED         (sw),
    .LOOP_CNT         (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    seg;
    int    cnt;
    bit    stop;
    bit    pend;
    bit    sw;
    bit    cnt_care;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic exp_push(input string tag, input int s, input int c, input bit st,
                          input bit p, input bit w, input bit cc = 1'b1);
    exp_t e;
    e.tag = tag; e.seg = s; e.cnt = c; e.stop = st; e.pend = p; e.sw = w; e.cnt_care = cc;
    exp_q.push_back(e);
  endtask

  // Advance one clock and compare every expectation queued for that edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      $display("cycle check %s: seg=%0d cnt=%0d stop=%0b pend=%0b sw=%0b", e.tag, seg, cnt, stop, pend, sw);
      check_val({e.tag, ".seg"}, 64'(seg), 64'(e.seg));
      if (e.cnt_care) check_val({e.tag, ".cnt"}, 64'(cnt), 64'(e.cnt));
      check_val({e.tag, ".stop"}, 64'(stop), 64'(e.stop));
      check_val({e.tag, ".pend"}, 64'(pend), 64'(e.pend));
      check_val({e.tag, ".sw"}, 64'(sw), 64'(e.sw));
    end
  endtask

  task automatic request(input logic [1:0] r, input logic [7:0] m, input logic [63:0] v);
    upd = 1'b1; req = r; mode = m; val = v;
  endtask

  initial begin
    rst = 1'b1; upd = 1'b0; req = '0; mode = '0; val = '0;
    rep_flat = {64{1'b1}}; wrap = 1'b0; systime = '0; gpio = '0;

    // Reset state
    exp_push("reset", 0, 0, 0, 0, 0); tick();
    rst = 1'b0;
    exp_push("idle", 0, 0, 0, 0, 0); tick();

    // IMMEDIATE to segment 2
    request(2'd2, 8'hAA, 64'd0);
    exp_push("imm_pend", 0, 0, 0, 1, 0); tick();
    upd = 1'b0;
    exp_push("imm_sw", 2, 0, 0, 0, 1); tick();
    exp_push("imm_after", 2, 0, 0, 0, 0); tick();

    // SYS_TIME target 1000 with time ramping up from 900
    systime = 64'd900;
    request(2'd1, 8'h01, 64'd1000);
    exp_push("tim_pend", 2, 0, 0, 1, 0); tick();
    upd = 1'b0; systime = 64'd950;
    exp_push("tim_early", 2, 0, 0, 1, 0); tick();
    systime = 64'd1000;
    exp_push("tim_sw", 1, 0, 0, 0, 1); tick();
    systime = 64'd1050;
    exp_push("tim_after", 1, 0, 0, 0, 0); tick();

    // GPIO line 2 already high: only a fresh rising edge switches
    gpio = 4'b0100;
    request(2'd3, 8'h02, 64'd2);
    exp_push("gpio_pend", 1, 0, 0, 1, 0); tick();
    upd = 1'b0;
    exp_push("gpio_high1", 1, 0, 0, 1, 0); tick();
    exp_push("gpio_high2", 1, 0, 0, 1, 0); tick();
    gpio = 4'b0000;
    exp_push("gpio_low", 1, 0, 0, 1, 0); tick();
    gpio = 4'b0100;
    exp_push("gpio_sw", 3, 0, 0, 0, 1); tick();
    gpio = 4'b0000;

    // Back to segment 0, then use up REP[0]=2
    request(2'd0, 8'h55, 64'd0);
    exp_push("seg0_pend", 3, 0, 0, 1, 0); tick();
    upd = 1'b0;
    exp_push("seg0_sw", 0, 0, 0, 0, 1); tick();
    rep_flat[15:0] = 16'd2;
    wrap = 1'b1;
    exp_push("rep_w1", 0, 1, 0, 0, 0); tick();
    exp_push("rep_w2", 0, 2, 0, 0, 0); tick();
    exp_push("rep_w3", 0, 2, 1, 0, 0); tick();
    exp_push("rep_w4", 0, 2, 1, 0, 0); tick();
    wrap = 1'b0;

    // EXT: leave HALT into segment 3 (REP=0), the next wrap auto-advances to 0
    rep_flat[63:48] = 16'd0;
    request(2'd3, 8'hF0, 64'd0);
    exp_push("ext_pend", 0, 2, 1, 1, 0); tick();
    upd = 1'b0; wrap = 1'b1;
    exp_push("ext_sw3", 3, 0, 0, 0, 1); tick();
    wrap = 1'b0;
    exp_push("ext_on3", 3, 0, 0, 0, 0); tick();
    wrap = 1'b1;
    exp_push("ext_adv0", 0, 0, 0, 0, 1); tick();
    exp_push("ext_cnt", 0, 1, 0, 0, 0); tick();
    wrap = 1'b0;

    // Request for the segment already active still performs a full switch
    request(2'd0, 8'h10, 64'd0);
    exp_push("same_pend", 0, 1, 0, 1, 0); tick();
    upd = 1'b0;
    exp_push("same_sw", 0, 0, 0, 0, 1); tick();

    // SYNC_IDX pending, then replaced on the same cycle as a wrap
    request(2'd2, 8'h00, 64'd0);
    exp_push("sync_pend", 0, 0, 0, 1, 0); tick();
    upd = 1'b0;
    exp_push("sync_wait", 0, 0, 0, 1, 0); tick();
    request(2'd1, 8'h00, 64'd0); wrap = 1'b1;
    exp_push("sync_repl", 0, 0, 0, 1, 0, 1'b0); tick();
    upd = 1'b0; wrap = 1'b0;
    exp_push("sync_hold", 0, 0, 0, 1, 0, 1'b0); tick();
    wrap = 1'b1;
    exp_push("sync_sw1", 1, 0, 0, 0, 1); tick();
    wrap = 1'b0;

    // SYS_TIME target already in the past switches on the first WAIT cycle
    systime = 64'd5000;
    request(2'd3, 8'h01, 64'd1000);
    exp_push("past_pend", 1, 0, 0, 1, 0); tick();
    upd = 1'b0;
    exp_push("past_sw", 3, 0, 0, 0, 1); tick();

    // Reset during WAIT drops the request with no SWITCHED pulse
    request(2'd2, 8'h00, 64'd0);
    exp_push("rw_pend", 3, 0, 0, 1, 0); tick();
    upd = 1'b0; rst = 1'b1;
    exp_push("rw_reset", 0, 0, 0, 0, 0); tick();
    rst = 1'b0;
    exp_push("rw_release", 0, 0, 0, 0, 0); tick();
    wrap = 1'b1;
    exp_push("rw_wrap", 0, 1, 0, 0, 0); tick();
    wrap = 1'b0;

    // STOP may assert while a GPIO request is still pending
    request(2'd1, 8'h02, 64'd0);
    exp_push("ws_pend", 0, 1, 0, 1, 0); tick();
    upd = 1'b0; wrap = 1'b1;
    exp_push("ws_w1", 0, 2, 0, 1, 0); tick();
    exp_push("ws_stop", 0, 2, 1, 1, 0); tick();
    wrap = 1'b0; gpio = 4'b0001;
    exp_push("ws_sw", 1, 0, 0, 0, 1); tick();
    gpio = 4'b0000;
    exp_push("ws_after", 1, 0, 0, 0, 0); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
